// File: rtl/writeback_stage.sv
// RV32 writeback stage: accepts retiring instructions, extracts and extends load data, and drives a registered register-file write port.
// Define WB_RETIRE_COUNT_EN to add the 64-bit retired_count output.
package writeback_stage_pkg;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr_rd;
    logic                  write_enable;
  } reg_file_write_params_t;
endpackage

module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr_rd,
  input  logic                   in_write_enable,
  input  logic                   in_is_load,
  input  logic [2:0]             in_load_funct3,
  input  logic [1:0]             in_byte_offset,
  input  logic [XLEN-1:0]        in_result,
  input  logic                   mem_rsp_valid,
  input  logic [XLEN-1:0]        mem_rsp_data,
  output reg_file_write_params_t write_params,
  output logic [XLEN-1:0]        data_rd,
  output logic                   busy,
  output logic                   fwd_valid,
  output logic [ADDR_W-1:0]      fwd_addr,
  output logic [XLEN-1:0]        fwd_data
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]            retired_count
`endif
);

  typedef enum logic {
    S_IDLE,
    S_WAIT_LOAD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  logic              take_alu;
  logic              take_load;
  logic              take_rsp;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [XLEN-1:0]   load_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    take_alu  = 1'b0;
    take_load = 1'b0;
    take_rsp  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_is_load) begin
            take_load = 1'b1;
            state_d   = S_WAIT_LOAD;
          end else begin
            take_alu = 1'b1;
          end
        end
      end
      S_WAIT_LOAD: begin
        busy = 1'b1;
        if (mem_rsp_valid) begin
          take_rsp = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lane_byte = mem_rsp_data[7:0];
    unique case (off_q)
      2'd0: lane_byte = mem_rsp_data[7:0];
      2'd1: lane_byte = mem_rsp_data[15:8];
      2'd2: lane_byte = mem_rsp_data[23:16];
      2'd3: lane_byte = mem_rsp_data[31:24];
      default: lane_byte = mem_rsp_data[7:0];
    endcase
    lane_half = off_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    unique case (f3_q)
      3'b000:  load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_half};
      default: load_data = mem_rsp_data;
    endcase
  end

  // Load context is captured at accept so the response may arrive any later cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      we_q  <= 1'b0;
      f3_q  <= '0;
      off_q <= '0;
    end else if (take_load) begin
      rd_q  <= in_addr_rd;
      we_q  <= in_write_enable;
      f3_q  <= in_load_funct3;
      off_q <= in_byte_offset;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_params <= '0;
      data_rd      <= '0;
    end else begin
      write_params.write_enable <= 1'b0;
      if (take_alu) begin
        write_params.addr_rd      <= in_addr_rd;
        write_params.write_enable <= in_write_enable && (in_addr_rd != '0);
        data_rd                   <= in_result;
      end else if (take_rsp) begin
        write_params.addr_rd      <= rd_q;
        write_params.write_enable <= we_q && (rd_q != '0);
        data_rd                   <= load_data;
      end
    end
  end

  assign fwd_valid = write_params.write_enable;
  assign fwd_addr  = write_params.addr_rd;
  assign fwd_data  = data_rd;

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 retired_count <= '0;
    else if (take_alu || take_rsp) retired_count <= retired_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a transaction-level model, plus directed literal checks.
module tb_writeback_stage;
  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr_rd = '0;
  logic        in_write_enable = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_load_funct3 = '0;
  logic [1:0]  in_byte_offset = '0;
  logic [31:0] in_result = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  writeback_stage_pkg::reg_file_write_params_t write_params;
  logic [31:0] data_rd;
  logic        busy;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retired_count;
`endif

  writeback_stage #(.XLEN(32), .ADDR_W(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr_rd(in_addr_rd), .in_write_enable(in_write_enable),
    .in_is_load(in_is_load), .in_load_funct3(in_load_funct3),
    .in_byte_offset(in_byte_offset), .in_result(in_result),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .write_params(write_params), .data_rd(data_rd), .busy(busy),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`ifdef WB_RETIRE_COUNT_EN
    , .retired_count(retired_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load semantics: shift the selected lane down, then extend.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * off);
    h = w >> (16 * off[1]);
    case (f3)
      3'd0:    return 32'($signed(b[7:0]));
      3'd1:    return 32'($signed(h[15:0]));
      3'd4:    return {24'd0, b[7:0]};
      3'd5:    return {16'd0, h[15:0]};
      default: return w;
    endcase
  endfunction

  // Model: one outstanding load at most, plus the last retired write.
  bit          m_pend = 0;
  logic [4:0]  p_rd = '0;
  bit          p_we = 0;
  logic [2:0]  p_f3 = '0;
  logic [1:0]  p_off = '0;
  bit          m_we = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [63:0] m_cnt = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    end else begin
      m_we = 0;
      if (m_pend) begin
        if (mem_rsp_valid) begin
          m_we   = p_we && (p_rd != 0);
          m_addr = p_rd;
          m_data = load_value(p_f3, p_off, mem_rsp_data);
          m_pend = 0;
          m_cnt  = m_cnt + 1;
        end
      end else if (in_valid) begin
        if (in_is_load) begin
          m_pend = 1; p_rd = in_addr_rd; p_we = in_write_enable;
          p_f3 = in_load_funct3; p_off = in_byte_offset;
        end else begin
          m_we   = in_write_enable && (in_addr_rd != 0);
          m_addr = in_addr_rd;
          m_data = in_result;
          m_cnt  = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("in_ready", in_ready, !m_pend);
    chk("busy", busy, m_pend);
    chk("write_enable", write_params.write_enable, m_we);
    chk("fwd_valid", fwd_valid, m_we);
    if (m_we) begin
      chk("addr_rd", write_params.addr_rd, m_addr);
      chk("data_rd", data_rd, m_data);
      chk("fwd_addr", fwd_addr, m_addr);
      chk("fwd_data", fwd_data, m_data);
    end
`ifdef WB_RETIRE_COUNT_EN
    chk("retired_count", retired_count, m_cnt);
`endif
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_is_load = 0; mem_rsp_valid = 0;
  endtask

  task automatic nl(input logic [4:0] rd, input logic we, input logic [31:0] res);
    in_valid = 1; in_is_load = 0; in_addr_rd = rd; in_write_enable = we; in_result = res;
    mem_rsp_valid = 0;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    in_valid = 1; in_is_load = 1; in_addr_rd = rd; in_write_enable = 1;
    in_load_funct3 = f3; in_byte_offset = off; mem_rsp_valid = 0;
  endtask

  task automatic rsp(input logic [31:0] w);
    in_valid = 0; mem_rsp_valid = 1; mem_rsp_data = w;
  endtask

  task automatic load_case(input string name, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] w, input int delay, input logic [31:0] exp);
    ld(5'd3, f3, off);
    step();
    idle_in();
    chk({name, "_ready_low"}, in_ready, 1'b0);
    for (int i = 0; i < delay; i++) begin
      chk({name, "_busy"}, busy, 1'b1);
      step();
    end
    rsp(w);
    step();
    idle_in();
    chk({name, "_data"}, data_rd, exp);
    chk({name, "_we"}, write_params.write_enable, 1'b1);
    chk({name, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #1 reset_n = 0;
    #20;
    chk("rst_we", write_params.write_enable, 1'b0);
    chk("rst_addr", write_params.addr_rd, 5'd0);
    chk("rst_data", data_rd, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    @(posedge clock); #1 reset_n = 1;
    chk("rst_ready", in_ready, 1'b1);

    nl(5'd0, 1'b1, 32'h1234);
    step(); idle_in();
    chk("x0_we", write_params.write_enable, 1'b0);
`ifdef WB_RETIRE_COUNT_EN
    chk("x0_count", retired_count, 64'd1);
`endif

    nl(5'd5, 1'b1, 32'hDEADBEEF);
    step(); idle_in();
    chk("nl_we", write_params.write_enable, 1'b1);
    chk("nl_addr", write_params.addr_rd, 5'd5);
    chk("nl_data", data_rd, 32'hDEADBEEF);
    chk("nl_fwd", fwd_valid, 1'b1);
    step();
    chk("nl_we_drop", write_params.write_enable, 1'b0);

    load_case("lb",  3'b000, 2'd2, 32'h12F03456, 0, 32'hFFFFFFF0);
    load_case("lbu", 3'b100, 2'd2, 32'h12F03456, 0, 32'h000000F0);
    load_case("lh",  3'b001, 2'd2, 32'h8001ABCD, 3, 32'hFFFF8001);
    load_case("lhu", 3'b101, 2'd2, 32'h8001ABCD, 3, 32'h00008001);
    load_case("lw",  3'b010, 2'd1, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    load_case("f3_7", 3'b111, 2'd3, 32'h89ABCDEF, 0, 32'h89ABCDEF);

    for (int i = 1; i <= 4; i++) begin
      nl(5'(i), 1'b1, 32'h100 + 32'(i));
      step();
      chk("b2b_we", write_params.write_enable, 1'b1);
      chk("b2b_addr", write_params.addr_rd, 5'(i));
      chk("b2b_ready", in_ready, 1'b1);
    end
    idle_in();

    for (int i = 0; i < 3000; i++) begin
      in_valid        = ($urandom_range(0, 3) != 0);
      in_is_load      = ($urandom_range(0, 9) < 4);
      in_addr_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_write_enable = ($urandom_range(0, 7) != 0);
      in_load_funct3  = 3'($urandom);
      in_byte_offset  = 2'($urandom);
      in_result       = $urandom;
      mem_rsp_valid   = ($urandom_range(0, 2) == 0);
      mem_rsp_data    = $urandom;
      step();
    end
    rsp(32'h0);
    step();
    idle_in();
    step();

    ld(5'd7, 3'b010, 2'd0);
    step(); idle_in();
    chk("mid_busy", busy, 1'b1);
    reset_n = 0;
    #2;
    chk("mid_rst_we", write_params.write_enable, 1'b0);
    chk("mid_rst_data", data_rd, 32'd0);
    chk("mid_rst_addr", write_params.addr_rd, 5'd0);
    chk("mid_rst_busy", busy, 1'b0);
`ifdef WB_RETIRE_COUNT_EN
    chk("mid_rst_count", retired_count, 64'd0);
`endif
    @(posedge clock); #1 reset_n = 1;
    rsp(32'h55555555);
    step(); idle_in();
    chk("late_rsp_we", write_params.write_enable, 1'b0);
    chk("late_rsp_ready", in_ready, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
